transmitter: RTL and testbench
==============================

TRANSMITTER -- requirements
Module: transmitter

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 1085, clken-qualified clock cycles per serial bit (start, data and stop bits alike).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, number of byte entries in the transmit FIFO (power of two, 2..16).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port clken  input  1  clock enable; the serial FSM advances only on clk edges where clken=1.
REQ-006 SHALL have port wr_en  input  1  byte-write strobe, one byte per clk cycle it is high.
REQ-007 SHALL have port din  input  8  byte to transmit, sampled when wr_en=1.
REQ-008 SHALL have port full  output  1  high when no further byte can be accepted.
REQ-009 SHALL have port overflow  output  1  sticky flag: a write was dropped.
REQ-010 SHALL have port busy  output  1  high while the FSM is outside IDLE or a byte is buffered.
REQ-011 SHALL have port tx  output  1  serial line, idle high, 8N1 frame, LSB first.

Function
REQ-012 SHALL implement states IDLE, START, DATA, STOP; IDLE->START->DATA->STOP->IDLE, no other transitions.
REQ-013 In IDLE on a clk edge with clken=1 and buffer non-empty, SHALL pop one byte into the shift register, drive tx<=0, clear the 16-bit bit counter and bit index, and enter START.
REQ-014 START, each DATA bit and STOP SHALL each hold tx constant for exactly CLKS_PER_BIT clken=1 edges; the counter counts 0..CLKS_PER_BIT-1, then wraps to 0 at the bit boundary.
REQ-015 DATA SHALL send bits 0..7 of the popped byte in that order; after bit 7 SHALL enter STOP with tx<=1.
REQ-016 At the end of STOP SHALL enter IDLE; a buffered byte SHALL start on the next clken=1 edge, giving at least one idle clken cycle between frames.
REQ-017 On edges with clken=0, FSM state, counter, bit index and tx SHALL hold; FIFO writes SHALL still be accepted.
REQ-018 A write is visible to the FSM the edge after wr_en; earliest tx fall is the first clken=1 edge after that.
REQ-019 full SHALL be registered-accurate: high exactly when the buffer holds its capacity.
REQ-020 wr_en=1 while full=1 SHALL drop the byte, set overflow, leave buffer contents unchanged, even if a pop occurs the same edge.
REQ-021 Simultaneous write and pop when not full SHALL both succeed; occupancy unchanged.
REQ-022 FIFO pointers SHALL wrap modulo FIFO_DEPTH; bytes SHALL leave in write order.
REQ-023 busy SHALL be 0 only when state=IDLE and buffer empty.

Reset
REQ-024 rst_n=0 SHALL immediately force state=IDLE, tx=1, counter=0, bit index=0, buffer empty, full=0, overflow=0, busy=0.
REQ-025 Reset asserted mid-frame SHALL abort the frame with tx high at once; buffered bytes SHALL be discarded.
REQ-026 After rst_n deasserts, overflow SHALL clear only by reset.

Configuration
REQ-027 With macro TX_FIFO_EN defined SHALL instantiate the FIFO_DEPTH-entry FIFO per REQ-019..022.
REQ-028 Without TX_FIFO_EN SHALL use a single-byte holding register (capacity 1), FIFO_DEPTH ignored; all other requirements unchanged.

Verification (CLKS_PER_BIT=4, clken=1 unless stated)
REQ-029 Write 0xA5 after reset -> tx: 4 cycles 0, bits 1,0,1,0,0,1,0,1 each 4 cycles, 4 cycles 1; busy falls after STOP.
REQ-030 Write 0x01,0x80,0xFF,0x00 back-to-back (TX_FIFO_EN) -> four frames in order, one idle clken cycle between; full high only while 4 held.
REQ-031 Fifth write while full -> overflow=1, byte never sent, other four frames intact.
REQ-032 clken toggled 1/0 every cycle during 0x3C -> every bit lasts 8 clk cycles; frame otherwise identical.
REQ-033 rst_n low during DATA bit 3 -> tx=1, busy=0, full=0 without a clk edge; new write after release sends a clean frame.

Source files
------------

// File: rtl/transmitter.sv
// 8N1 serial transmitter with clock-enabled bit timing and a byte write buffer.
// Define TX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise a single-byte holding register is used.
module transmitter #(
   parameter int CLKS_PER_BIT = 1085,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clken,
   input  logic       wr_en,
   input  logic [7:0] din,
   output logic       full,
   output logic       overflow,
   output logic       busy,
   output logic       tx
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

`ifdef TX_FIFO_EN
   localparam int CAP = FIFO_DEPTH;
   localparam int AW  = $clog2(FIFO_DEPTH);
`else
   localparam int CAP = 1;
`endif
   localparam int          CW   = $clog2(CAP + 1);
   localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

   state_t          state_r, state_n_s;
   logic [15:0]     cnt_r, cnt_n_s;
   logic [2:0]      idx_r, idx_n_s;
   logic [7:0]      shift_r, shift_n_s;
   logic            tx_r, tx_n_s;
   logic [CW-1:0]   count_r, count_n_s;
   logic            full_r, overflow_r, busy_r;
   logic            push_s, pop_s;
   logic [7:0]      head_s;

`ifdef TX_FIFO_EN
   logic [7:0]      mem_r [FIFO_DEPTH];
   logic [AW-1:0]   wptr_r, rptr_r;
   assign head_s = mem_r[rptr_r];
`else
   logic [7:0]      hold_r;
   assign head_s = hold_r;
`endif

   // A write while full is dropped even if the FSM pops on the same edge.
   assign push_s = wr_en & ~full_r;
   assign pop_s  = clken & (state_r == IDLE) & (count_r != {CW{1'b0}});

   // Buffer occupancy for the next edge
   always_comb begin
      count_n_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_n_s = count_r + CW'(1'b1);
         2'b01:   count_n_s = count_r - CW'(1'b1);
         default: count_n_s = count_r;
      endcase
   end

   // Serial FSM next-state and datapath
   always_comb begin
      state_n_s = state_r;
      cnt_n_s   = cnt_r;
      idx_n_s   = idx_r;
      shift_n_s = shift_r;
      tx_n_s    = tx_r;
      if (clken) begin
         case (state_r)
            IDLE: begin
               if (pop_s) begin
                  shift_n_s = head_s;
                  tx_n_s    = 1'b0;
                  cnt_n_s   = 16'd0;
                  idx_n_s   = 3'd0;
                  state_n_s = START;
               end else begin
                  state_n_s = IDLE;
               end
            end
            START: begin
               if (cnt_r == LAST) begin
                  cnt_n_s   = 16'd0;
                  tx_n_s    = shift_r[0];
                  state_n_s = DATA;
               end else begin
                  cnt_n_s = cnt_r + 16'd1;
               end
            end
            DATA: begin
               if (cnt_r == LAST) begin
                  cnt_n_s = 16'd0;
                  if (idx_r == 3'd7) begin
                     tx_n_s    = 1'b1;
                     state_n_s = STOP;
                  end else begin
                     // shift_r[0] always holds the bit currently on the line
                     idx_n_s   = idx_r + 3'd1;
                     shift_n_s = {1'b1, shift_r[7:1]};
                     tx_n_s    = shift_r[1];
                  end
               end else begin
                  cnt_n_s = cnt_r + 16'd1;
               end
            end
            STOP: begin
               if (cnt_r == LAST) begin
                  cnt_n_s   = 16'd0;
                  state_n_s = IDLE;
               end else begin
                  cnt_n_s = cnt_r + 16'd1;
               end
            end
            default: begin
               state_n_s = IDLE;
               tx_n_s    = 1'b1;
            end
         endcase
      end else begin
         state_n_s = state_r;
      end
   end

   // Serial FSM registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         cnt_r   <= 16'd0;
         idx_r   <= 3'd0;
         shift_r <= 8'd0;
         tx_r    <= 1'b1;
      end else begin
         state_r <= state_n_s;
         cnt_r   <= cnt_n_s;
         idx_r   <= idx_n_s;
         shift_r <= shift_n_s;
         tx_r    <= tx_n_s;
      end
   end

   // Buffer bookkeeping and registered status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r    <= {CW{1'b0}};
         full_r     <= 1'b0;
         overflow_r <= 1'b0;
         busy_r     <= 1'b0;
`ifdef TX_FIFO_EN
         wptr_r     <= {AW{1'b0}};
         rptr_r     <= {AW{1'b0}};
`endif
      end else begin
         count_r    <= count_n_s;
         full_r     <= (count_n_s == CW'(CAP));
         overflow_r <= overflow_r | (wr_en & full_r);
         busy_r     <= (state_n_s != IDLE) | (count_n_s != {CW{1'b0}});
`ifdef TX_FIFO_EN
         if (push_s) wptr_r <= wptr_r + AW'(1'b1);
         if (pop_s)  rptr_r <= rptr_r + AW'(1'b1);
`endif
      end
   end

`ifdef TX_FIFO_EN
   // FIFO storage; contents are meaningless while the occupancy says empty
   always_ff @(posedge clk) begin
      if (push_s) mem_r[wptr_r] <= din;
   end
`else
   // Holding register storage
   always_ff @(posedge clk) begin
      if (push_s) hold_r <= din;
   end
`endif

   assign tx       = tx_r;
   assign full     = full_r;
   assign overflow = overflow_r;
   assign busy     = busy_r;

endmodule

// File: tb/tb_transmitter.sv
// Scoreboard bench for transmitter: a line monitor decodes 8N1 frames and checks timing and byte order.
module tb_transmitter;

   localparam int CPB = 4;
`ifdef TX_FIFO_EN
   localparam int CAP = 4;
`else
   localparam int CAP = 1;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       clken;
   logic       wr_en;
   logic [7:0] din;
   logic       full, overflow, busy, tx;

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] sb[$];
   int         bit_clks = CPB;
   bit         in_frame = 1'b0;
   bit         clk_toggle = 1'b0;
   logic       clken_lvl = 1'b1;

   // monitor state
   int         mb;
   bit         m_abort, m_good;
   logic [7:0] m_rx, m_exp;
   logic       m_samp [0:127];

   transmitter #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .clken    (clken),
      .wr_en    (wr_en),
      .din      (din),
      .full     (full),
      .overflow (overflow),
      .busy     (busy),
      .tx       (tx)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic write_byte(input logic [7:0] b, input bit push);
      @(posedge clk); #1;
      wr_en = 1'b1;
      din   = b;
      if (push) sb.push_back(b);
      @(posedge clk); #1;
      wr_en = 1'b0;
   endtask

   task automatic wait_idle(input int limit);
      int n = 0;
      while ((sb.size() != 0 || in_frame) && n < limit) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", n < limit, 1);
      repeat (3) @(negedge clk);
      chk("busy_after_stop", busy, 0);
      chk("tx_idle_high", tx, 1);
   endtask

   // clock-enable driver: level or 1/0 toggle every cycle
   initial begin
      clken = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (clk_toggle) clken = ~clken;
         else            clken = clken_lvl;
      end
   end

   // line monitor: samples tx on falling clk edges, bit windows relative to the start bit
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && tx === 1'b0) begin
            in_frame  = 1'b1;
            mb        = bit_clks;
            m_abort   = 1'b0;
            m_samp[0] = tx;
            for (int s = 1; s <= 10 * mb; s++) begin
               @(negedge clk);
               if (rst_n !== 1'b1) begin
                  m_abort = 1'b1;
                  break;
               end
               m_samp[s] = tx;
            end
            if (!m_abort) begin
               m_good = 1'b1;
               for (int j = 0; j < 10; j++)
                  for (int k = 0; k < mb; k++)
                     if (m_samp[j*mb+k] !== m_samp[j*mb+mb/2]) m_good = 1'b0;
               for (int i = 0; i < 8; i++) m_rx[i] = m_samp[(i+1)*mb+mb/2];
               chk("bit_timing", m_good, 1);
               chk("stop_bit", m_samp[9*mb+mb/2], 1);
               chk("idle_gap", m_samp[10*mb], 1);
               chk("frame_expected", sb.size() != 0, 1);
               if (sb.size() != 0) begin
                  m_exp = sb.pop_front();
                  chk("frame_byte", m_rx, m_exp);
               end
            end
            in_frame = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] burst [5];
      int occ;
      int n;
      bit acc;
      burst = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h5A};
      rst_n = 1'b0;
      wr_en = 1'b0;
      din   = 8'h00;
      #12;
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_full", full, 0);
      chk("rst_overflow", overflow, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // single frame 0xA5
      write_byte(8'hA5, 1'b1);
      chk("busy_on_write", busy, 1);
      chk("overflow_clear", overflow, 0);
      wait_idle(2000);

      // fill buffer with the FSM frozen, one write too many
      clken_lvl = 1'b0;
      repeat (2) @(posedge clk);
      occ = 0;
      for (int i = 0; i < 5; i++) begin
         acc = (occ < CAP);
         write_byte(burst[i], acc);
         if (acc) occ++;
         chk("full_burst", full, occ == CAP);
      end
      chk("overflow_set", overflow, 1);
      chk("tx_frozen", tx, 1);
      chk("busy_buffered", busy, 1);
      clken_lvl = 1'b1;
      wait_idle(3000);
      chk("overflow_sticky", overflow, 1);
      chk("full_drained", full, 0);

      // only reset clears overflow
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("overflow_reset", overflow, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      sb.delete();

      // clken toggling: every bit lasts 2*CPB clk cycles
      bit_clks   = 2 * CPB;
      clk_toggle = 1'b1;
      write_byte(8'h3C, 1'b1);
      wait_idle(4000);
      clk_toggle = 1'b0;
      clken_lvl  = 1'b1;
      repeat (2) @(posedge clk);
      bit_clks = CPB;

      // reset during data bit 3 with another byte buffered
      write_byte(8'hC3, 1'b1);
      n = 0;
      while (tx !== 1'b0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("frame_start", n < 100, 1);
      write_byte(8'h99, 1'b0);
      repeat (16) @(negedge clk);
      chk("full_midframe", full, CAP == 1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("abort_tx", tx, 1);
      chk("abort_busy", busy, 0);
      chk("abort_full", full, 0);
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      write_byte(8'h6E, 1'b1);
      wait_idle(2000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
